// File: rtl/regfile_sb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | regfile_sb : multi-read-port GPR file with EX/MEM/WB forwarding and a    |
// |              per-register pending scoreboard for long-latency producers. |
// | Optional debug read port: define REGFILE_DEBUG_EN.                       |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
module regfile_sb #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NUM_RD = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     we,
   input  logic [ADDR_W-1:0]        waddr,
   input  logic [DATA_W-1:0]        wdata,
   input  logic [NUM_RD-1:0]        re,
   input  logic [NUM_RD*ADDR_W-1:0] raddr,
   output logic [NUM_RD*DATA_W-1:0] rdata,
   input  logic                     ex_wreg,
   input  logic [ADDR_W-1:0]        ex_wd,
   input  logic [DATA_W-1:0]        ex_wdata,
   input  logic                     ex_is_load,
   input  logic                     mem_wreg,
   input  logic [ADDR_W-1:0]        mem_wd,
   input  logic [DATA_W-1:0]        mem_wdata,
   input  logic                     iss_valid,
   input  logic [ADDR_W-1:0]        iss_dst,
   output logic                     stall_req,
   output logic                     pending_any
`ifdef REGFILE_DEBUG_EN
   ,
   input  logic [ADDR_W-1:0]        debug_addr,
   output logic [DATA_W-1:0]        debug_data
`endif
);

   localparam int c_DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0]  r_mem [0:c_DEPTH-1];
   logic [c_DEPTH-1:0] r_pending;
   logic [NUM_RD-1:0]  w_hz;

   // Array and scoreboard; on a same-address issue/retire, the new issue keeps the bit set.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int k = 0; k < c_DEPTH; k++) begin
            r_mem[k] <= '0;
         end
         r_pending <= '0;
      end else begin
         if (we && (waddr != '0)) begin
            r_mem[waddr] <= wdata;
         end
         r_pending[0] <= 1'b0;
         for (int j = 1; j < c_DEPTH; j++) begin
            if (iss_valid && (iss_dst == ADDR_W'(j))) begin
               r_pending[j] <= 1'b1;
            end else if (we && (waddr == ADDR_W'(j))) begin
               r_pending[j] <= 1'b0;
            end
         end
      end
   end

   generate
      for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
         logic [ADDR_W-1:0] w_ra;
         logic [DATA_W-1:0] w_rd;
         logic              w_wb_hit;

         assign w_ra     = raddr[i*ADDR_W +: ADDR_W];
         assign w_wb_hit = we && (waddr == w_ra);

         always_comb begin
            w_rd = '0;
            if (!rst || !re[i] || (w_ra == '0)) begin
               w_rd = '0;
            end else if (ex_wreg && (ex_wd == w_ra) && !ex_is_load) begin
               w_rd = ex_wdata;
            end else if (mem_wreg && (mem_wd == w_ra)) begin
               w_rd = mem_wdata;
            end else if (w_wb_hit) begin
               w_rd = wdata;
            end else begin
               w_rd = r_mem[w_ra];
            end
         end

         // A MEM match never retires a pending register; only the WB write does.
         assign w_hz[i] = rst && re[i] && (w_ra != '0) &&
                          ((ex_wreg && ex_is_load && (ex_wd == w_ra)) ||
                           (r_pending[w_ra] && !w_wb_hit));

         assign rdata[i*DATA_W +: DATA_W] = w_rd;
      end
   endgenerate

   assign stall_req   = |w_hz;
   assign pending_any = rst && (|r_pending);

`ifdef REGFILE_DEBUG_EN
   always_comb begin
      debug_data = '0;
      if (!rst || (debug_addr == '0)) begin
         debug_data = '0;
      end else if (ex_wreg && (ex_wd == debug_addr) && !ex_is_load) begin
         debug_data = ex_wdata;
      end else if (mem_wreg && (mem_wd == debug_addr)) begin
         debug_data = mem_wdata;
      end else if (we && (waddr == debug_addr)) begin
         debug_data = wdata;
      end else begin
         debug_data = r_mem[debug_addr];
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_regfile_sb : directed self-checking bench for regfile_sb.             |
// | Revision      : 1.0                                                      |
// +--------------------------------------------------------------------------+
module tb_regfile_sb;

   logic        clk;
   logic        rst;
   logic        we;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic [1:0]  re;
   logic [9:0]  raddr;
   logic [63:0] rdata;
   logic        ex_wreg;
   logic [4:0]  ex_wd;
   logic [31:0] ex_wdata;
   logic        ex_is_load;
   logic        mem_wreg;
   logic [4:0]  mem_wd;
   logic [31:0] mem_wdata;
   logic        iss_valid;
   logic [4:0]  iss_dst;
   logic        stall_req;
   logic        pending_any;

   int total = 0;
   int bad   = 0;

   regfile_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) dut (
      .clk         (clk),
      .rst         (rst),
      .we          (we),
      .waddr       (waddr),
      .wdata       (wdata),
      .re          (re),
      .raddr       (raddr),
      .rdata       (rdata),
      .ex_wreg     (ex_wreg),
      .ex_wd       (ex_wd),
      .ex_wdata    (ex_wdata),
      .ex_is_load  (ex_is_load),
      .mem_wreg    (mem_wreg),
      .mem_wd      (mem_wd),
      .mem_wdata   (mem_wdata),
      .iss_valid   (iss_valid),
      .iss_dst     (iss_dst),
      .stall_req   (stall_req),
      .pending_any (pending_any)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0; we = 1'b0; waddr = '0; wdata = '0; re = '0; raddr = '0;
      ex_wreg = 1'b0; ex_wd = '0; ex_wdata = '0; ex_is_load = 1'b0;
      mem_wreg = 1'b0; mem_wd = '0; mem_wdata = '0; iss_valid = 1'b0; iss_dst = '0;

      // Reset: writes and issues are ignored, outputs held low
      tick();
      we = 1'b1; waddr = 5'd5; wdata = 32'hDEAD_BEEF;
      iss_valid = 1'b1; iss_dst = 5'd9;
      re = 2'b11; raddr = {5'd9, 5'd5};
      #1;
      chk("rst_rdata0", rdata[31:0], 32'h0);
      chk("rst_stall", {31'b0, stall_req}, 32'h0);
      chk("rst_pend", {31'b0, pending_any}, 32'h0);
      tick();
      rst = 1'b1; we = 1'b0; iss_valid = 1'b0;
      #1;
      chk("post_rst_pend", {31'b0, pending_any}, 32'h0);
      chk("post_rst_r5", rdata[31:0], 32'h0);
      chk("post_rst_stall", {31'b0, stall_req}, 32'h0);

      // 1: write bypass then array read
      we = 1'b1; waddr = 5'd5; wdata = 32'h1234_5678; re = 2'b01; raddr = {5'd0, 5'd5};
      #1;
      chk("t1_bypass", rdata[31:0], 32'h1234_5678);
      tick();
      we = 1'b0;
      #1;
      chk("t1_array", rdata[31:0], 32'h1234_5678);

      // 2: forwarding priority EX > MEM > WB
      ex_wreg = 1'b1; ex_wd = 5'd3; ex_wdata = 32'hAAAA;
      mem_wreg = 1'b1; mem_wd = 5'd3; mem_wdata = 32'hBBBB;
      we = 1'b1; waddr = 5'd3; wdata = 32'hCCCC; raddr = {5'd0, 5'd3};
      #1;
      chk("t2_ex", rdata[31:0], 32'hAAAA);
      ex_wreg = 1'b0;
      #1;
      chk("t2_mem", rdata[31:0], 32'hBBBB);
      mem_wreg = 1'b0;
      #1;
      chk("t2_wb", rdata[31:0], 32'hCCCC);
      tick();
      we = 1'b0;
      // EX load data is not forwarded; array value shows and a stall is raised
      ex_wreg = 1'b1; ex_is_load = 1'b1; ex_wd = 5'd3; ex_wdata = 32'h5555;
      #1;
      chk("t2_load_nofwd", rdata[31:0], 32'hCCCC);
      chk("t2_load_stall", {31'b0, stall_req}, 32'h1);

      // 3: load-use hazard on port 1
      ex_wd = 5'd7; re = 2'b10; raddr = {5'd7, 5'd0};
      #1;
      chk("t3_lu_stall", {31'b0, stall_req}, 32'h1);
      re = 2'b00;
      #1;
      chk("t3_re_off", {31'b0, stall_req}, 32'h0);
      re = 2'b10; ex_wd = 5'd0; raddr = {5'd0, 5'd0};
      #1;
      chk("t3_r0_stall", {31'b0, stall_req}, 32'h0);
      chk("t3_r0_data", rdata[63:32], 32'h0);
      ex_wreg = 1'b0; ex_is_load = 1'b0;
      mem_wreg = 1'b1; mem_wd = 5'd7; mem_wdata = 32'h77; raddr = {5'd7, 5'd0};
      #1;
      chk("t3_p1_mem", rdata[63:32], 32'h77);
      mem_wreg = 1'b0;

      // 4: scoreboard stall until WB retire
      tick();
      iss_valid = 1'b1; iss_dst = 5'd9;
      tick();
      iss_valid = 1'b0; re = 2'b01; raddr = {5'd0, 5'd9};
      #1;
      chk("t4_pend", {31'b0, pending_any}, 32'h1);
      chk("t4_stall_c1", {31'b0, stall_req}, 32'h1);
      tick();
      mem_wreg = 1'b1; mem_wd = 5'd9; mem_wdata = 32'h88;
      #1;
      chk("t4_stall_c2_mem", {31'b0, stall_req}, 32'h1);
      chk("t4_mem_data", rdata[31:0], 32'h88);
      tick();
      mem_wreg = 1'b0;
      #1;
      chk("t4_stall_c3", {31'b0, stall_req}, 32'h1);
      tick();
      we = 1'b1; waddr = 5'd9; wdata = 32'h99;
      #1;
      chk("t4_wb_nostall", {31'b0, stall_req}, 32'h0);
      chk("t4_wb_data", rdata[31:0], 32'h99);
      tick();
      we = 1'b0;
      #1;
      chk("t4_pend_clr", {31'b0, pending_any}, 32'h0);
      chk("t4_after_stall", {31'b0, stall_req}, 32'h0);
      chk("t4_after_data", rdata[31:0], 32'h99);

      // 5: set and clear on same edge -> stays pending, data written
      iss_valid = 1'b1; iss_dst = 5'd4; we = 1'b1; waddr = 5'd4; wdata = 32'h44;
      raddr = {5'd0, 5'd0};
      tick();
      iss_valid = 1'b0; we = 1'b0; raddr = {5'd0, 5'd4};
      #1;
      chk("t5_pend", {31'b0, pending_any}, 32'h1);
      chk("t5_stall", {31'b0, stall_req}, 32'h1);
      chk("t5_data", rdata[31:0], 32'h44);
      we = 1'b1; waddr = 5'd4; wdata = 32'h45;
      tick();
      we = 1'b0;
      #1;
      chk("t5_retired", {31'b0, pending_any}, 32'h0);

      // 6: reset discards pending state; r0 stays zero and never pends
      iss_valid = 1'b1; iss_dst = 5'd10;
      tick();
      iss_valid = 1'b0; raddr = {5'd0, 5'd10};
      #1;
      chk("t6_pend_set", {31'b0, pending_any}, 32'h1);
      rst = 1'b0;
      #1;
      chk("t6_rst_stall", {31'b0, stall_req}, 32'h0);
      chk("t6_rst_pend", {31'b0, pending_any}, 32'h0);
      tick();
      rst = 1'b1;
      #1;
      chk("t6_pend_clr", {31'b0, pending_any}, 32'h0);
      chk("t6_r10", rdata[31:0], 32'h0);
      chk("t6_nostall", {31'b0, stall_req}, 32'h0);
      raddr = {5'd0, 5'd5};
      #1;
      chk("t6_r5_cleared", rdata[31:0], 32'h0);
      we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF; raddr = {5'd0, 5'd0};
      iss_valid = 1'b1; iss_dst = 5'd0;
      #1;
      chk("t6_r0_same", rdata[31:0], 32'h0);
      tick();
      we = 1'b0; iss_valid = 1'b0;
      #1;
      chk("t6_r0_next", rdata[31:0], 32'h0);
      chk("t6_r0_nopend", {31'b0, pending_any}, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
